depth_colour_mapper: RTL and testbench

Pipelined colour stage between the Mandelbrot engine's depth output and the RGB pixel packer. It accepts one escape-depth per handshake with start-of-frame/end-of-line sideband, maps it to 24-bit RGB, and forwards it with valid/ready backpressure. Three mapping modes are supported: inverted greyscale, a host-written palette with static offset, and a palette with an offset that advances every frame. This replaces the inline combinational colour assignment in the pixel generator.

---
 rtl/depth_colour_mapper_if.sv | 29 ++
 rtl/depth_colour_mapper.sv | 163 ++++++++++++++++
 tb/tb_depth_colour_mapper.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/depth_colour_mapper_if.sv
// Depth-in / RGB-out stream bundle for the colour mapper.
// The mapper takes the slave side; the depth source and the pixel packer sit on the master side.
interface depth_colour_mapper_if #(
    parameter int DEPTH_WIDTH = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DEPTH_WIDTH-1:0] in_depth;
    logic                   in_sof;
    logic                   in_eol;

    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_r;
    logic [7:0]             out_g;
    logic [7:0]             out_b;
    logic                   out_sof;
    logic                   out_eol;

    modport slave (
        input  in_valid, in_depth, in_sof, in_eol, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b, out_sof, out_eol
    );

    modport master (
        output in_valid, in_depth, in_sof, in_eol, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b, out_sof, out_eol
    );
endinterface

// File: rtl/depth_colour_mapper.sv
// Two-stage escape-depth to RGB colour mapper with greyscale and palette modes.
// The palette offset is frame-latched on each start-of-frame beat.
module depth_colour_mapper #(
    parameter int DEPTH_WIDTH  = 10,
    parameter int MAX_ITER     = 512,
    parameter int MAX_ITER_LOG = 9,
    parameter int PAL_AWIDTH   = 8
) (
    input  logic                  out_stream_aclk,
    input  logic                  periph_resetn,
    depth_colour_mapper_if.slave  bus,
    input  logic [1:0]            mode,
    input  logic [7:0]            pal_offset,
    input  logic                  pal_we,
    input  logic [PAL_AWIDTH-1:0] pal_waddr,
    input  logic [23:0]           pal_wdata
);

    function automatic logic uses_palette(input logic [1:0] m);
        return (m == 2'd1) || (m == 2'd2);
    endfunction

    function automatic logic [7:0] grey_level(input logic [7:0] s);
        return 8'hFF - s;
    endfunction

    logic       en;
    logic       accept;
    logic       sof_beat;
    logic [1:0] frame_mode;
    logic [1:0] eff_mode;
    logic [7:0] frame_off;
    logic [7:0] eff_off;
    logic [7:0] cyc_cnt;
    logic [7:0] scaled_p0;
    logic       interior_p0;

    logic       vld_p1;
    logic       sof_p1;
    logic       eol_p1;
    logic       interior_p1;
    logic       pal_p1;
    logic [7:0] scaled_p1;
    logic [7:0] idx_p1;

    logic        vld_p2;
    logic        sof_p2;
    logic        eol_p2;
    logic        zero_p2;
    logic        pal_p2;
    logic [7:0]  grey_p2;
    logic [23:0] ram_q_p2;
    logic [23:0] rgb_p2;

    logic [23:0] pal_ram [2**PAL_AWIDTH];

    assign en          = bus.out_ready | ~vld_p2;
    assign bus.in_ready = en;
    assign accept      = bus.in_valid & en;
    assign sof_beat    = accept & bus.in_sof;
    assign scaled_p0   = bus.in_depth[MAX_ITER_LOG-1 -: 8];
    assign interior_p0 = int'(bus.in_depth) >= MAX_ITER;

    // The sof pixel must already see its own frame's mode and offset.
    always_comb begin
        eff_mode = frame_mode;
        eff_off  = frame_off;
        if (sof_beat) begin
            eff_mode = mode;
            case (mode)
                2'd1:    eff_off = pal_offset;
                2'd2:    eff_off = cyc_cnt;
                default: eff_off = 8'd0;
            endcase
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            frame_mode <= 2'd0;
            frame_off  <= 8'd0;
            cyc_cnt    <= 8'd0;
        end else if (sof_beat) begin
            frame_mode <= eff_mode;
            frame_off  <= eff_off;
            if (mode == 2'd2) begin
                cyc_cnt <= cyc_cnt + 8'd1;
            end
        end
    end

    // Stage 1: classify depth, scale to 8 bits, form palette index
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eol_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= bus.in_valid;
            sof_p1 <= bus.in_sof & bus.in_valid;
            eol_p1 <= bus.in_eol & bus.in_valid;
        end
    end

    always_ff @(posedge out_stream_aclk) begin
        if (en) begin
            interior_p1 <= interior_p0;
            scaled_p1   <= scaled_p0;
            idx_p1      <= scaled_p0 + eff_off;
            pal_p1      <= uses_palette(eff_mode);
        end
    end

    // Stage 2: palette lookup or grey level; bubbles and interior present black
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            vld_p2  <= 1'b0;
            sof_p2  <= 1'b0;
            eol_p2  <= 1'b0;
            zero_p2 <= 1'b1;
            pal_p2  <= 1'b0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            sof_p2  <= sof_p1;
            eol_p2  <= eol_p1;
            zero_p2 <= ~vld_p1 | interior_p1;
            pal_p2  <= pal_p1;
        end
    end

    always_ff @(posedge out_stream_aclk) begin
        if (en) begin
            grey_p2 <= grey_level(scaled_p1);
        end
    end

    // Read-first: a write and a read of the same entry in one cycle returns the old entry.
    always_ff @(posedge out_stream_aclk) begin
        if (pal_we) begin
            pal_ram[pal_waddr] <= pal_wdata;
        end
        if (en) begin
            ram_q_p2 <= pal_ram[PAL_AWIDTH'(idx_p1)];
        end
    end

    always_comb begin
        rgb_p2 = {3{grey_p2}};
        if (zero_p2) begin
            rgb_p2 = 24'h000000;
        end else if (pal_p2) begin
            rgb_p2 = ram_q_p2;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_sof   = sof_p2;
    assign bus.out_eol   = eol_p2;
    assign bus.out_r     = rgb_p2[23:16];
    assign bus.out_g     = rgb_p2[15:8];
    assign bus.out_b     = rgb_p2[7:0];

endmodule

// File: tb/tb_depth_colour_mapper.sv
// Self-checking bench for depth_colour_mapper: vector table plus scoreboard-checked
// sequences for latency, stalls, palette read-first and mid-run reset.
module tb_depth_colour_mapper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode;
    logic [7:0]  pal_offset;
    logic        pal_we;
    logic [7:0]  pal_waddr;
    logic [23:0] pal_wdata;

    depth_colour_mapper_if #(.DEPTH_WIDTH(10)) bus ();

    depth_colour_mapper #(
        .DEPTH_WIDTH(10), .MAX_ITER(512), .MAX_ITER_LOG(9), .PAL_AWIDTH(8)
    ) dut (
        .out_stream_aclk(clk),
        .periph_resetn  (rst_n),
        .bus            (bus),
        .mode           (mode),
        .pal_offset     (pal_offset),
        .pal_we         (pal_we),
        .pal_waddr      (pal_waddr),
        .pal_wdata      (pal_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } exp_t;

    typedef struct {
        logic [9:0]  depth;
        logic        sof;
        logic        eol;
        logic [1:0]  mode;
        logic [7:0]  off;
        logic [23:0] rgb;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   popped = 0;
    bit   mon_stall = 0;
    logic [26:0] held = '0;
    bit   done = 0;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [23:0] grey_exp(input int d);
        logic [7:0] s;
        if (d >= 512) return 24'h000000;
        s = 8'(d / 2);
        return {3{8'(255 - int'(s))}};
    endfunction

    task automatic monitor();
        exp_t e;
        logic [26:0] now;
        forever begin
            @(negedge clk);
            now = {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_r, bus.out_g, bus.out_b};
            if (mon_stall && rst_n) chk("stall_hold", 32'(now), 32'(held));
            mon_stall = rst_n && bus.out_valid && !bus.out_ready;
            held = now;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    chk($sformatf("pixel_%0d", popped), 32'(now[25:0]), 32'({e.sof, e.eol, e.rgb}));
                end
            end
        end
    endtask

    task automatic send(input logic [9:0] d, input logic sof, input logic eol,
                        input exp_t e, input bit push);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_depth = d;
        bus.in_sof   = sof;
        bus.in_eol   = eol;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 4000);
        if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.in_depth  = '0;
        bus.in_sof    = 1'b0;
        bus.in_eol    = 1'b0;
        bus.out_ready = 1'b1;
        mode       = 2'd0;
        pal_offset = 8'd0;
        pal_we     = 1'b0;
        pal_waddr  = 8'd0;
        pal_wdata  = 24'd0;

        //               depth  sof eol mode off    rgb
        tbl[0]  = '{10'd0,    1'b1, 1'b0, 2'd0, 8'd0,  24'hFFFFFF};
        tbl[1]  = '{10'd2,    1'b0, 1'b0, 2'd0, 8'd0,  24'hFEFEFE};
        tbl[2]  = '{10'd506,  1'b0, 1'b0, 2'd0, 8'd0,  24'h020202};
        tbl[3]  = '{10'd510,  1'b0, 1'b0, 2'd0, 8'd0,  24'h000000};
        tbl[4]  = '{10'd512,  1'b0, 1'b0, 2'd0, 8'd0,  24'h000000};
        tbl[5]  = '{10'd1023, 1'b0, 1'b1, 2'd0, 8'd0,  24'h000000};
        tbl[6]  = '{10'd10,   1'b1, 1'b0, 2'd1, 8'd3,  24'h08F755};
        tbl[7]  = '{10'd600,  1'b0, 1'b0, 2'd1, 8'd3,  24'h000000};
        tbl[8]  = '{10'd511,  1'b0, 1'b1, 2'd1, 8'd3,  24'h02FD55};
        tbl[9]  = '{10'd0,    1'b1, 1'b0, 2'd2, 8'd0,  24'h00FF55};
        tbl[10] = '{10'd4,    1'b0, 1'b0, 2'd0, 8'd0,  24'h02FD55};
        tbl[11] = '{10'd0,    1'b1, 1'b0, 2'd2, 8'd0,  24'h01FE55};
        tbl[12] = '{10'd0,    1'b1, 1'b0, 2'd2, 8'd0,  24'h02FD55};
        tbl[13] = '{10'd0,    1'b0, 1'b1, 2'd1, 8'd50, 24'h02FD55};
        tbl[14] = '{10'd0,    1'b1, 1'b0, 2'd1, 8'd50, 24'h32CD55};
        tbl[15] = '{10'd0,    1'b1, 1'b1, 2'd3, 8'd0,  24'hFFFFFF};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rgb", 32'({bus.out_r, bus.out_g, bus.out_b}), 32'd0);
        chk("rst_sideband", 32'({bus.out_sof, bus.out_eol}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // First-beat latency
        send(10'd0, 1'b1, 1'b0, '{24'hFFFFFF, 1'b1, 1'b0}, 1'b1);
        idle();
        @(negedge clk);
        chk("latency_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2", 32'(bus.out_valid), 32'd1);
        drain();

        // Palette load: entry k = {k, ~k, 0x55}
        @(posedge clk);
        #1;
        for (int k = 0; k < 256; k++) begin
            pal_we    = 1'b1;
            pal_waddr = 8'(k);
            pal_wdata = {8'(k), ~8'(k), 8'h55};
            @(posedge clk);
            #1;
        end
        pal_we = 1'b0;

        for (int i = 0; i < 16; i++) begin
            mode       = tbl[i].mode;
            pal_offset = tbl[i].off;
            send(tbl[i].depth, tbl[i].sof, tbl[i].eol,
                 '{tbl[i].rgb, tbl[i].sof, tbl[i].eol}, 1'b1);
        end
        idle();
        drain();

        // Palette write colliding with the stage-1 read of the same entry
        mode       = 2'd1;
        pal_offset = 8'd0;
        send(10'd40, 1'b1, 1'b0, '{24'h14EB55, 1'b1, 1'b0}, 1'b1);
        idle();
        pal_we    = 1'b1;
        pal_waddr = 8'd20;
        pal_wdata = 24'hABCDEF;
        @(posedge clk);
        #1;
        pal_we = 1'b0;
        send(10'd40, 1'b0, 1'b0, '{24'hABCDEF, 1'b0, 1'b0}, 1'b1);
        idle();
        drain();

        // 960 pixels under random backpressure
        mode = 2'd0;
        base = popped;
        done = 0;
        fork
            begin
                for (int i = 0; i < 960; i++) begin
                    send(10'(i), i == 0, i == 959, '{grey_exp(i), i == 0, i == 959}, 1'b1);
                end
                idle();
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("stall_run_count", 32'(popped - base), 32'd960);

        // Reset with two pixels in flight
        mode = 2'd0;
        send(10'd100, 1'b1, 1'b0, '{24'h0, 1'b0, 1'b0}, 1'b0);
        send(10'd200, 1'b0, 1'b0, '{24'h0, 1'b0, 1'b0}, 1'b0);
        idle();
        chk("flush_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("flush_no_output", 32'(bus.out_valid), 32'd0);

        // Frame state was reset to grey, so a mid-frame palette mode is ignored
        @(posedge clk);
        #1;
        mode = 2'd1;
        send(10'd4, 1'b0, 1'b0, '{24'hFDFDFD, 1'b0, 1'b0}, 1'b1);
        idle();
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
